// File: rtl/serial_bus_arbiter_if.sv
// Serial system bus bundle: per-master request/serial lines plus the shared slave side.
// master: the arbiter's view (it masters the shared bus); slave: the surrounding masters/slaves.
interface serial_bus_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 2
);
    logic [NUM_MASTERS-1:0] m_bus_req;
    logic [NUM_MASTERS-1:0] m_bus_grant;
    logic [NUM_MASTERS-1:0] m_addr;
    logic [NUM_MASTERS-1:0] m_wr_data;
    logic [NUM_MASTERS-1:0] m_wr_en;
    logic [NUM_MASTERS-1:0] m_valid;
    logic [NUM_MASTERS-1:0] m_slave_ready;
    logic                   m_rd_data;
    logic                   s_addr;
    logic                   s_wr_data;
    logic                   s_wr_en;
    logic                   s_valid;
    logic                   s_ready;
    logic                   s_rd_data;

    modport master (
        input  m_bus_req, m_addr, m_wr_data, m_wr_en, m_valid, s_ready, s_rd_data,
        output m_bus_grant, m_slave_ready, m_rd_data, s_addr, s_wr_data, s_wr_en, s_valid
    );

    modport slave (
        output m_bus_req, m_addr, m_wr_data, m_wr_en, m_valid, s_ready, s_rd_data,
        input  m_bus_grant, m_slave_ready, m_rd_data, s_addr, s_wr_data, s_wr_en, s_valid
    );
endinterface

// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter for the single-bit serial system bus; grant held for one 24-beat transaction.
// Define ARB_TIMEOUT_EN to abort transactions whose slave stalls for TIMEOUT cycles.
module serial_bus_arbiter #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_BITS   = 16,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned FREE_BEATS  = 4,
    parameter int unsigned TIMEOUT     = 64,
    localparam int unsigned IDX_W      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_bus_arbiter_if.master bus,
    output logic                 busy,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 timeout_err
);
    localparam int unsigned TOTAL_BEATS = ADDR_BITS + DATA_BITS;
    localparam int unsigned BEAT_W      = $clog2(TOTAL_BEATS + 1);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || FREE_BEATS >= TOTAL_BEATS || TIMEOUT < 1) begin : g_bad_cfg
        $error("serial_bus_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {IDLE, ACK, XFER, GAP} state_t;

    state_t                 state, state_d;
    logic [NUM_MASTERS-1:0] grant, grant_d;
    logic [IDX_W-1:0]       idx_d;
    logic [IDX_W-1:0]       cand;
    logic                   found;
    logic [BEAT_W-1:0]      beat_cnt, beat_d;
    logic                   beat_ok;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);
    logic [STALL_W-1:0] stall_cnt, stall_d;
    logic               err_d;
`endif

    always_comb begin
        state_d = state;
        grant_d = grant;
        idx_d   = grant_idx;
        beat_d  = beat_cnt;
        cand    = '0;
        found   = 1'b0;
        beat_ok = (beat_cnt < BEAT_W'(FREE_BEATS)) || bus.s_ready;
`ifdef ARB_TIMEOUT_EN
        stall_d = stall_cnt;
        err_d   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (|bus.m_bus_req) begin
                    // Search starts one past the last winner so every requester gets a turn.
                    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
                        cand = IDX_W'((32'(grant_idx) + k) % NUM_MASTERS);
                        if (!found && bus.m_bus_req[cand]) begin
                            found   = 1'b1;
                            idx_d   = cand;
                            grant_d = NUM_MASTERS'(1) << cand;
                        end
                    end
                    state_d = ACK;
                end
            end
            ACK: begin
                beat_d  = '0;
                state_d = XFER;
`ifdef ARB_TIMEOUT_EN
                stall_d = '0;
`endif
            end
            XFER: begin
                if (beat_ok) begin
                    beat_d = beat_cnt + BEAT_W'(1);
                    if (beat_cnt == BEAT_W'(TOTAL_BEATS - 1)) begin
                        state_d = GAP;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                if (bus.s_ready) begin
                    stall_d = '0;
                end else if (!beat_ok) begin
                    if (stall_cnt == STALL_W'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        grant_d = '0;
                        stall_d = '0;
                        state_d = GAP;
                    end else begin
                        stall_d = stall_cnt + STALL_W'(1);
                    end
                end
`endif
            end
            GAP: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= IDX_W'(NUM_MASTERS - 1);
            beat_cnt  <= '0;
        end else begin
            state     <= state_d;
            grant     <= grant_d;
            grant_idx <= idx_d;
            beat_cnt  <= beat_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            stall_cnt   <= stall_d;
            timeout_err <= err_d;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    // Grant is one-hot or zero, so AND-OR gives the mux and forces zeros when idle.
    assign bus.m_bus_grant   = grant;
    assign bus.s_addr        = |(bus.m_addr & grant);
    assign bus.s_wr_data     = |(bus.m_wr_data & grant);
    assign bus.s_wr_en       = |(bus.m_wr_en & grant);
    assign bus.s_valid       = |(bus.m_valid & grant);
    assign bus.m_slave_ready = grant & {NUM_MASTERS{bus.s_ready}};
    assign bus.m_rd_data     = bus.s_rd_data;
    assign busy              = (state == ACK) || (state == XFER);
endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Bench for serial_bus_arbiter: grant/hold-length scoreboard plus directed timing and mux checks.
module tb_serial_bus_arbiter;
    localparam int unsigned NM = 2;
    localparam int unsigned IW = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          busy;
    logic [IW-1:0] grant_idx;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NM-1:0] grant;
        int            hold;
    } exp_t;
    exp_t sb_q[$];

    serial_bus_arbiter_if #(.NUM_MASTERS(NM)) bus ();

    serial_bus_arbiter #(
        .NUM_MASTERS(NM),
        .ADDR_BITS  (16),
        .DATA_BITS  (8),
        .FREE_BEATS (4),
        .TIMEOUT    (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.master),
        .busy       (busy),
        .grant_idx  (grant_idx),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input logic [NM-1:0] g, input int hold);
        exp_t e;
        e.grant = g;
        e.hold  = hold;
        sb_q.push_back(e);
    endtask

    task automatic wait_release(input string tag);
        int n;
        n = 0;
        while (bus.m_bus_grant != '0 && n < 300) begin
            tick();
            n++;
        end
        if (bus.m_bus_grant != '0) check(tag, bus.m_bus_grant, 0);
    endtask

    // Scoreboard: pop on each new grant, compare owner and held cycles when it drops.
    logic [NM-1:0] mon_grant = '0;
    int            mon_hold  = 0;
    exp_t          mon_exp;
    always @(negedge clk) begin
        if (bus.m_bus_grant !== '0 && mon_grant === '0) begin
            mon_grant <= bus.m_bus_grant;
            mon_hold  <= 1;
            if (sb_q.size() > 0) begin
                mon_exp <= sb_q.pop_front();
            end else begin
                check("sb_unexpected_grant", bus.m_bus_grant, 0);
                mon_exp <= '{'0, 0};
            end
        end else if (bus.m_bus_grant !== '0) begin
            if (bus.m_bus_grant !== mon_grant) check("sb_grant_stable", bus.m_bus_grant, mon_grant);
            mon_hold <= mon_hold + 1;
        end else if (mon_grant !== '0) begin
            check("sb_grant", mon_grant, mon_exp.grant);
            check("sb_hold", mon_hold, mon_exp.hold);
            mon_grant <= '0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ngrant, zeros, n;
        logic [NM-1:0] prev;

        rst               = 1'b1;
        bus.m_bus_req     = '0;
        bus.m_addr        = '0;
        bus.m_wr_data     = '0;
        bus.m_wr_en       = '0;
        bus.m_valid       = '1;
        bus.s_ready       = 1'b1;
        bus.s_rd_data     = 1'b0;
        repeat (3) tick();
        check("rst_grant", bus.m_bus_grant, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_idx", grant_idx, NM - 1);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_s_valid", bus.s_valid, 0);
        check("rst_slave_ready", bus.m_slave_ready, 0);

        // Both masters request continuously: 01,10,01,10 with one idle cycle between.
        rst           = 1'b0;
        bus.m_bus_req = '1;
        expect_grant(2'b01, 26);
        expect_grant(2'b10, 26);
        expect_grant(2'b01, 26);
        expect_grant(2'b10, 26);
        ngrant = 0;
        zeros  = 0;
        n      = 0;
        prev   = '0;
        while (ngrant < 4 && n < 300) begin
            tick();
            n++;
            if (bus.m_bus_grant != '0 && prev == '0) begin
                ngrant++;
                if (ngrant > 1) check("rr_gap", zeros, 1);
                zeros = 0;
            end else if (bus.m_bus_grant == '0) begin
                zeros++;
            end
            prev = bus.m_bus_grant;
        end
        check("rr_grants", ngrant, 4);
        bus.m_bus_req = '0;
        wait_release("rr_release");

        // Single request from master 0, exact release timing with s_ready high.
        bus.m_bus_req = 2'b01;
        expect_grant(2'b01, 26);
        tick();
        check("single_grant", bus.m_bus_grant, 2'b01);
        check("single_busy", busy, 1);
        check("single_idx", grant_idx, 0);
        bus.m_bus_req = '0;
        repeat (24) tick();
        check("single_busy_xfer", busy, 1);
        tick();
        check("single_gap_grant", bus.m_bus_grant, 2'b01);
        check("single_gap_busy", busy, 0);
        tick();
        check("single_released", bus.m_bus_grant, 0);
        check("single_idx_hold", grant_idx, 0);

        // Master 1 with s_ready low for 10 cycles once 4 free beats are consumed.
        bus.m_bus_req = 2'b10;
        expect_grant(2'b10, 36);
        tick();
        check("stall_grant", bus.m_bus_grant, 2'b10);
        bus.m_bus_req = '0;
        repeat (5) tick();
        check("stall_ready_pre", bus.m_slave_ready, 2'b10);
        bus.s_ready = 1'b0;
        #1;
        check("stall_ready_low", bus.m_slave_ready, 2'b00);
        repeat (10) tick();
        bus.s_ready = 1'b1;
        #1;
        check("stall_ready_back", bus.m_slave_ready, 2'b10);
        repeat (19) tick();
        check("stall_busy_last", busy, 1);
        tick();
        check("stall_gap_busy", busy, 0);
        tick();
        check("stall_released", bus.m_bus_grant, 0);

        // Mux: master 0 granted, master 1 drives conflicting lines.
        bus.m_wr_data = 2'b10;
        bus.m_wr_en   = 2'b10;
        bus.m_valid   = 2'b10;
        bus.m_bus_req = 2'b01;
        expect_grant(2'b01, 26);
        tick();
        bus.m_bus_req = '0;
        for (int i = 0; i < 8; i++) begin
            logic a, r;
            a             = (i % 2 == 0);
            r             = ((i / 2) % 2 == 1);
            bus.m_addr    = {1'b1, a};
            bus.s_rd_data = r;
            #1;
            check("mux_s_addr", bus.s_addr, a);
            check("mux_rd_data", bus.m_rd_data, r);
            tick();
        end
        check("mux_s_valid_low", bus.s_valid, 0);
        check("mux_s_wr_data_low", bus.s_wr_data, 0);
        bus.m_wr_data = 2'b01;
        bus.m_wr_en   = 2'b01;
        bus.m_valid   = 2'b01;
        #1;
        check("mux_s_wr_data", bus.s_wr_data, 1);
        check("mux_s_wr_en", bus.s_wr_en, 1);
        check("mux_s_valid", bus.s_valid, 1);
        wait_release("mux_release");
        bus.m_addr  = '1;
        bus.m_valid = '1;
        #1;
        check("idle_s_addr", bus.s_addr, 0);
        check("idle_s_valid", bus.s_valid, 0);
        check("idle_slave_ready", bus.m_slave_ready, 0);

        // Reset at beat 10 aborts, pointer returns to NUM_MASTERS-1.
        bus.m_bus_req = 2'b01;
        expect_grant(2'b01, 12);
        tick();
        check("abort_grant", bus.m_bus_grant, 2'b01);
        bus.m_bus_req = '0;
        repeat (11) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_grant_clr", bus.m_bus_grant, 0);
        check("abort_busy", busy, 0);
        check("abort_idx", grant_idx, NM - 1);
        bus.m_bus_req = '1;
        expect_grant(2'b01, 26);
        tick();
        check("abort_rr_grant", bus.m_bus_grant, 2'b01);
        bus.m_bus_req = '0;
        wait_release("abort_release");

        // Slave stuck low after the free beats.
        bus.m_bus_req = 2'b10;
`ifdef ARB_TIMEOUT_EN
        expect_grant(2'b10, 69);
`else
        expect_grant(2'b10, 90);
`endif
        tick();
        check("to_grant", bus.m_bus_grant, 2'b10);
        bus.m_bus_req = '0;
        repeat (5) tick();
        bus.s_ready = 1'b0;
        repeat (63) tick();
        check("to_err_early", timeout_err, 0);
        check("to_grant_held", bus.m_bus_grant, 2'b10);
        tick();
`ifdef ARB_TIMEOUT_EN
        check("to_err_pulse", timeout_err, 1);
        check("to_grant_drop", bus.m_bus_grant, 0);
        tick();
        check("to_err_end", timeout_err, 0);
        bus.s_ready = 1'b1;
`else
        check("to_err_off", timeout_err, 0);
        check("to_still_held", bus.m_bus_grant, 2'b10);
        bus.s_ready = 1'b1;
        wait_release("to_release");
`endif
        bus.m_bus_req = 2'b01;
        expect_grant(2'b01, 26);
        tick();
        check("to_next_grant", bus.m_bus_grant, 2'b01);
        bus.m_bus_req = '0;
        wait_release("to_next_release");

        repeat (3) tick();
        check("sb_drain", sb_q.size(), 0);
        check("sb_idle", mon_grant, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
